mul_div_sequencer: RTL
======================

// Module: mul_div_sequencer
// PURPOSE
//  Multi-cycle unsigned multiply/divide controller built around one shared 32-bit ripple adder/subtractor
//  (x + (y ^ {32{cin}}) + cin; cin=1 gives x - y, cout=1 means no borrow).
//  Sequences the adder one iteration per clock: 32 shift-add steps for MUL, 32 restoring steps for DIVU.
//  Sits beside the ALU and is launched by the execute stage with start/done.
//  The adder is instantiated in the parent; this block drives fa_x/fa_y/fa_cin and samples fa_sum/fa_cout.
// PARAMETERS
//  WIDTH  32  operand width; must equal adder width. Only 32 is supported.
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      launch request; sampled only in IDLE or DONE
//  op           in   1      0 = MUL, 1 = DIVU
//  a            in   32     MUL: multiplicand; DIVU: dividend
//  b            in   32     MUL: multiplier; DIVU: divisor
//  busy         out  1      high while in CALC
//  done         out  1      one-cycle pulse when results are valid
//  result_lo    out  32     MUL: product[31:0]; DIVU: quotient
//  result_hi    out  32     MUL: product[63:32]; DIVU: remainder
//  div_by_zero  out  1      set with done when DIVU and b==0; held until next accepted start
//  fa_x         out  32     adder operand x
//  fa_y         out  32     adder operand y
//  fa_cin       out  1      adder carry-in / subtract select
//  fa_sum       in   32     adder sum
//  fa_cout      in   1      adder carry-out
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high. Reset has priority over start.
//    Reset state: IDLE. busy=0, done=0, result_lo=0, result_hi=0, div_by_zero=0, step counter=0.
//    Reset mid-operation aborts with no done pulse.
//  - States:
//    IDLE -start-> CALC, or DONE when DIVU with b==0.
//    CALC -> DONE after the 32nd step (counter 31).
//    DONE -> IDLE, or -start-> CALC.
//  - Start acceptance: start in CALC is ignored (no queueing). a, b and op are registered at acceptance.
//  - Latency: accept at edge 0; steps at edges 1..32; done=1 in the cycle after edge 32 (33 cycles start-to-done).
//  - MUL, registers hi=0, lo=b, m=a. Each step:
//    - lo[0]=1: fa_x=hi, fa_y=m, fa_cin=0; {hi,lo} <= {fa_cout, fa_sum, lo[31:1]}.
//    - lo[0]=0: {hi,lo} <= {1'b0, hi, lo[31:1]}.
//  - DIVU, registers rem=0, q=a. Each step: s = {rem[30:0], q[31]}, t = rem[31].
//    fa_x=s, fa_y=b, fa_cin=1.
//    - t|fa_cout: rem <= fa_sum; q <= {q[30:0], 1'b1}.
//    - Otherwise: rem <= s; q <= {q[30:0], 1'b0}.
//  - Outside CALC (IDLE or DONE): fa_x=0, fa_y=0, fa_cin=0. In CALC they are combinational from state registers only.
//  - result_lo/result_hi update only on the transition into DONE and hold until the next transition into DONE or reset.
//  - Divide by zero: 2-cycle path: result_lo=32'hFFFF_FFFF, result_hi=a, div_by_zero=1.
//  - Back-to-back: start while done=1 is accepted; busy rises next cycle.
// CONFIGURATION
//  MULDIV_DIV_EN defined:
//    - DIVU path, div_by_zero logic and fa_cin=1 steps are present.
//  MULDIV_DIV_EN undefined:
//    - The op input is ignored and every start runs MUL.
//    - div_by_zero is tied to 0; fa_cin is tied to 0.
// TESTING
//  1. MUL a=7, b=6 -> done at cycle 33; hi=0, lo=42; busy high for exactly 32 cycles.
//  2. MUL a=b=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001.
//  3. DIVU a=100, b=7 -> lo=14, hi=2; DIVU a=32'hFFFF_FFFF, b=32'h8000_0001 -> lo=1, hi=32'h7FFF_FFFE.
//  4. DIVU a=5, b=0 -> done 2 cycles after start; lo=32'hFFFF_FFFF, hi=5, div_by_zero=1;
//     the following MUL clears div_by_zero.
//  5. start pulsed at step 10 of a MUL 3*4 -> ignored; result 12. rst at step 20 of a second op -> IDLE next cycle,
//     no done, outputs 0.
//  6. Build without MULDIV_DIV_EN: op=1, a=9, b=3 -> MUL result lo=27; fa_cin never 1.

Source files
------------

// File: rtl/mul_div_sequencer.sv
// Multi-cycle unsigned MUL / DIVU sequencer that drives a shared external 32-bit adder one step per clock.
// Optional macro MULDIV_DIV_EN adds the DIVU path; without it every start runs MUL.
module mul_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] fa_x,
    output logic [WIDTH-1:0] fa_y,
    output logic             fa_cin,
    input  logic [WIDTH-1:0] fa_sum,
    input  logic             fa_cout
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;      // MUL: product high half; DIVU: partial remainder
    logic [WIDTH-1:0] r_lo;      // MUL: multiplier / product low half; DIVU: dividend / quotient
    logic [WIDTH-1:0] r_m;       // MUL: multiplicand; DIVU: divisor
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_res_hi;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic             w_is_div;
    logic             w_start_div;
    logic             w_calc;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_hi_n;
    logic [WIDTH-1:0] w_lo_n;

`ifdef MULDIV_DIV_EN
    logic r_op;
    assign w_is_div    = r_op;
    assign w_start_div = op;
`else
    logic w_unused_op;
    assign w_unused_op = op;
    assign w_is_div    = 1'b0;
    assign w_start_div = 1'b0;
`endif

    assign busy        = r_busy;
    assign done        = r_done;
    assign result_lo   = r_res_lo;
    assign result_hi   = r_res_hi;
    assign div_by_zero = r_dbz;

    // Adder operands depend only on state registers, so the loop through the parent's adder is acyclic.
    assign w_calc = (r_state == S_CALC);
    assign w_s    = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign fa_x   = w_calc ? (w_is_div ? w_s : r_hi) : '0;
    assign fa_y   = w_calc ? r_m : '0;
    assign fa_cin = w_calc & w_is_div;

    always_comb begin
        w_hi_n = r_hi;
        w_lo_n = r_lo;
        if (w_is_div) begin
            // A set top bit of the shifted remainder means it already exceeds any 32-bit divisor.
            if (r_hi[WIDTH-1] | fa_cout) begin
                w_hi_n = fa_sum;
                w_lo_n = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_n = w_s;
                w_lo_n = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else if (r_lo[0]) begin
            w_hi_n = {fa_cout, fa_sum[WIDTH-1:1]};
            w_lo_n = {fa_sum[0], r_lo[WIDTH-1:1]};
        end else begin
            w_hi_n = {1'b0, r_hi[WIDTH-1:1]};
            w_lo_n = {r_hi[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_res_lo <= '0;
            r_res_hi <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_op     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_CALC: begin
                    r_hi  <= w_hi_n;
                    r_lo  <= w_lo_n;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_res_lo <= w_lo_n;
                        r_res_hi <= w_hi_n;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                    if (start) begin
                        r_dbz <= 1'b0;
                        r_hi  <= '0;
                        r_cnt <= '0;
`ifdef MULDIV_DIV_EN
                        r_op  <= op;
`endif
                        if (w_start_div) begin
                            r_lo <= a;
                            r_m  <= b;
                        end else begin
                            r_lo <= b;
                            r_m  <= a;
                        end
                        // Division by zero skips CALC: results are known at acceptance.
                        if (w_start_div && (b == '0)) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_res_lo <= '1;
                            r_res_hi <= a;
                            r_dbz    <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
